// File: rtl/mem_pkg.sv
// mem_pkg: address map, MemtoReg encoding and TCON bit positions
// shared by the MEM stage and its data RAM.
package mem_pkg;

  localparam logic [31:0] ADDR_RAM_BASE = 32'h0000_0000;
  localparam logic [31:0] ADDR_TH       = 32'h4000_0000;
  localparam logic [31:0] ADDR_TL       = 32'h4000_0004;
  localparam logic [31:0] ADDR_TCON     = 32'h4000_0008;
  localparam logic [31:0] ADDR_LED      = 32'h4000_000C;
  localparam logic [31:0] ADDR_SWITCH   = 32'h4000_0010;
  localparam logic [31:0] ADDR_DIGI     = 32'h4000_0014;

  localparam logic [1:0] MTR_ALU = 2'b00;
  localparam logic [1:0] MTR_MEM = 2'b01;
  localparam logic [1:0] MTR_PC  = 2'b10;

  localparam int TCON_EN = 0;
  localparam int TCON_IE = 1;
  localparam int TCON_IS = 2;

endpackage

// File: rtl/mem_data_ram.sv
// data_ram: word-wide data memory, asynchronous read, synchronous
// write, contents are not reset.
module data_ram #(
  parameter int WORDS = 256,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [WORDS];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mem_stage.sv
// mem_stage: EX/MEM register, RAM and peripheral access, MEM/WB register.
// Timer (TH/TL/TCON, irq) present only when PERIPH_TIMER_EN is defined.
module mem_stage
  import mem_pkg::*;
#(
  parameter int RAM_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        EX_RegWrite,
  input  logic [4:0]  EX_RegDest,
  input  logic        EX_MemRead,
  input  logic        EX_MemWrite,
  input  logic [1:0]  EX_MemtoReg,
  input  logic [31:0] EX_ALUOut,
  input  logic [31:0] EX_WrData,
  input  logic [7:0]  switch,
  output logic [31:0] MEMForwardSrc,
  output logic        MEM_RegWrite,
  output logic [4:0]  MEM_RegDest,
  output logic        WB_RegWrite,
  output logic [4:0]  WB_RegDest,
  output logic [31:0] WB_WrBack,
  output logic [7:0]  led,
  output logic [11:0] digi,
  output logic        irq
);

  localparam int AW = $clog2(RAM_WORDS);

  logic        mem_regwrite_q;
  logic [4:0]  mem_regdest_q;
  logic        mem_memread_q;
  logic        mem_memwrite_q;
  logic [1:0]  mem_memtoreg_q;
  logic [31:0] mem_aluout_q;
  logic [31:0] mem_wrdata_q;

  logic        wb_regwrite_q;
  logic [4:0]  wb_regdest_q;
  logic [31:0] wb_wrback_q;
  logic [31:0] wb_wrback_d;

  logic [7:0]  led_q, led_d;
  logic [11:0] digi_q, digi_d;

  logic [31:0] addr_w;
  logic        ram_hit;
  logic        st_en;
  logic [31:0] ram_rdata;
  logic [31:0] rdata;
  logic [31:0] ld_data;

  assign addr_w  = {mem_aluout_q[31:2], 2'b00};
  assign ram_hit = (mem_aluout_q[31:AW+2] == '0);
  // A store caught in EX/MEM during reset must not reach memory.
  assign st_en   = mem_memwrite_q & ~reset;

  data_ram #(
    .WORDS (RAM_WORDS),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .we_i    (st_en & ram_hit),
    .addr_i  (mem_aluout_q[AW+1:2]),
    .wdata_i (mem_wrdata_q),
    .rdata_o (ram_rdata)
  );

`ifdef PERIPH_TIMER_EN
  logic [31:0] th_q, th_d;
  logic [31:0] tl_q, tl_d;
  logic [2:0]  tcon_q, tcon_d;

  always_comb begin
    th_d   = th_q;
    tl_d   = tl_q;
    tcon_d = tcon_q;
    if (tcon_q[TCON_EN]) begin
      if (tl_q == 32'hFFFF_FFFF) begin
        tl_d = th_q;
        if (tcon_q[TCON_IE]) tcon_d[TCON_IS] = 1'b1;
      end else begin
        tl_d = tl_q + 32'd1;
      end
    end
    if (st_en && addr_w == ADDR_TH)   th_d   = mem_wrdata_q;
    if (st_en && addr_w == ADDR_TL)   tl_d   = mem_wrdata_q;
    if (st_en && addr_w == ADDR_TCON) tcon_d = mem_wrdata_q[2:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      th_q   <= '0;
      tl_q   <= '0;
      tcon_q <= '0;
    end else begin
      th_q   <= th_d;
      tl_q   <= tl_d;
      tcon_q <= tcon_d;
    end
  end

  assign irq = tcon_q[TCON_IE] & tcon_q[TCON_IS];
`else
  assign irq = 1'b0;
`endif

  always_comb begin
    rdata = '0;
    if (ram_hit) begin
      rdata = ram_rdata;
    end else begin
      unique case (addr_w)
`ifdef PERIPH_TIMER_EN
        ADDR_TH:     rdata = th_q;
        ADDR_TL:     rdata = tl_q;
        ADDR_TCON:   rdata = {29'd0, tcon_q};
`endif
        ADDR_LED:    rdata = {24'd0, led_q};
        ADDR_SWITCH: rdata = {24'd0, switch};
        ADDR_DIGI:   rdata = {20'd0, digi_q};
        default:     rdata = '0;
      endcase
    end
  end

  always_comb begin
    ld_data = mem_memread_q ? rdata : '0;
    wb_wrback_d = (mem_memtoreg_q == MTR_MEM) ? ld_data : mem_aluout_q;
    led_d  = led_q;
    digi_d = digi_q;
    if (st_en && addr_w == ADDR_LED)  led_d  = mem_wrdata_q[7:0];
    if (st_en && addr_w == ADDR_DIGI) digi_d = mem_wrdata_q[11:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_regwrite_q <= 1'b0;
      mem_regdest_q  <= '0;
      mem_memread_q  <= 1'b0;
      mem_memwrite_q <= 1'b0;
      mem_memtoreg_q <= MTR_ALU;
      mem_aluout_q   <= '0;
      mem_wrdata_q   <= '0;
      wb_regwrite_q  <= 1'b0;
      wb_regdest_q   <= '0;
      wb_wrback_q    <= '0;
      led_q          <= '0;
      digi_q         <= '0;
    end else begin
      mem_regwrite_q <= EX_RegWrite;
      mem_regdest_q  <= EX_RegDest;
      mem_memread_q  <= EX_MemRead;
      mem_memwrite_q <= EX_MemWrite;
      mem_memtoreg_q <= EX_MemtoReg;
      mem_aluout_q   <= EX_ALUOut;
      mem_wrdata_q   <= EX_WrData;
      wb_regwrite_q  <= mem_regwrite_q;
      wb_regdest_q   <= mem_regdest_q;
      wb_wrback_q    <= wb_wrback_d;
      led_q          <= led_d;
      digi_q         <= digi_d;
    end
  end

  assign MEMForwardSrc = mem_aluout_q;
  assign MEM_RegWrite  = mem_regwrite_q;
  assign MEM_RegDest   = mem_regdest_q;
  assign WB_RegWrite   = wb_regwrite_q;
  assign WB_RegDest    = wb_regdest_q;
  assign WB_WrBack     = wb_wrback_q;
  assign led           = led_q;
  assign digi          = digi_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed vectors for mem_stage; timer checks follow
// PERIPH_TIMER_EN so the bench matches whichever build is compiled.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        EX_RegWrite;
  logic [4:0]  EX_RegDest;
  logic        EX_MemRead;
  logic        EX_MemWrite;
  logic [1:0]  EX_MemtoReg;
  logic [31:0] EX_ALUOut;
  logic [31:0] EX_WrData;
  logic [7:0]  switch;
  logic [31:0] MEMForwardSrc;
  logic        MEM_RegWrite;
  logic [4:0]  MEM_RegDest;
  logic        WB_RegWrite;
  logic [4:0]  WB_RegDest;
  logic [31:0] WB_WrBack;
  logic [7:0]  led;
  logic [11:0] digi;
  logic        irq;

  int n_checks = 0;
  int n_errors = 0;

  mem_stage #(.RAM_WORDS(256)) dut (
    .clk           (clk),
    .reset         (reset),
    .EX_RegWrite   (EX_RegWrite),
    .EX_RegDest    (EX_RegDest),
    .EX_MemRead    (EX_MemRead),
    .EX_MemWrite   (EX_MemWrite),
    .EX_MemtoReg   (EX_MemtoReg),
    .EX_ALUOut     (EX_ALUOut),
    .EX_WrData     (EX_WrData),
    .switch        (switch),
    .MEMForwardSrc (MEMForwardSrc),
    .MEM_RegWrite  (MEM_RegWrite),
    .MEM_RegDest   (MEM_RegDest),
    .WB_RegWrite   (WB_RegWrite),
    .WB_RegDest    (WB_RegDest),
    .WB_WrBack     (WB_WrBack),
    .led           (led),
    .digi          (digi),
    .irq           (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present one instruction and clock it into EX/MEM.
  task automatic issue(input logic        rw,
                       input logic [4:0]  rd,
                       input logic        mr,
                       input logic        mw,
                       input logic [1:0]  m2r,
                       input logic [31:0] alu,
                       input logic [31:0] wd);
    EX_RegWrite = rw;
    EX_RegDest  = rd;
    EX_MemRead  = mr;
    EX_MemWrite = mw;
    EX_MemtoReg = m2r;
    EX_ALUOut   = alu;
    EX_WrData   = wd;
    @(posedge clk);
    #1;
  endtask

  task automatic nop();
    issue(1'b0, 5'd0, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    issue(1'b0, 5'd0, 1'b0, 1'b1, 2'b00, a, d);
  endtask

  task automatic load(input logic [4:0] rd, input logic [31:0] a);
    issue(1'b1, rd, 1'b1, 1'b0, 2'b01, a, 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " fwd"},   MEMForwardSrc, 32'd0);
    check({tag, " mrw"},   {31'd0, MEM_RegWrite}, 32'd0);
    check({tag, " mrd"},   {27'd0, MEM_RegDest}, 32'd0);
    check({tag, " wbrw"},  {31'd0, WB_RegWrite}, 32'd0);
    check({tag, " wbrd"},  {27'd0, WB_RegDest}, 32'd0);
    check({tag, " wb"},    WB_WrBack, 32'd0);
    check({tag, " led"},   {24'd0, led}, 32'd0);
    check({tag, " digi"},  {20'd0, digi}, 32'd0);
    check({tag, " irq"},   {31'd0, irq}, 32'd0);
  endtask

  initial begin
    reset  = 1'b1;
    switch = 8'h00;
    EX_RegWrite = 1'b0;
    EX_RegDest  = '0;
    EX_MemRead  = 1'b0;
    EX_MemWrite = 1'b0;
    EX_MemtoReg = '0;
    EX_ALUOut   = '0;
    EX_WrData   = '0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("rst");
    reset = 1'b0;

    // RAM store then load
    store(32'h10, 32'hDEAD_BEEF);
    load(5'd9, 32'h10);
    check("ld mrd", {27'd0, MEM_RegDest}, 32'd9);
    check("ld mrw", {31'd0, MEM_RegWrite}, 32'd1);
    nop();
    check("ld wb", WB_WrBack, 32'hDEAD_BEEF);
    check("ld wbrd", {27'd0, WB_RegDest}, 32'd9);
    check("ld wbrw", {31'd0, WB_RegWrite}, 32'd1);

    // ALU forwarding, back to back
    issue(1'b1, 5'd3, 1'b0, 1'b0, 2'b00, 32'd5, 32'd0);
    check("fwd5", MEMForwardSrc, 32'd5);
    issue(1'b1, 5'd4, 1'b0, 1'b0, 2'b00, 32'd7, 32'd0);
    check("fwd7", MEMForwardSrc, 32'd7);
    check("wb5", WB_WrBack, 32'd5);
    issue(1'b1, 5'd31, 1'b0, 1'b0, 2'b10, 32'h0000_0044, 32'd0);
    check("wb7", WB_WrBack, 32'd7);
    nop();
    check("wb link", WB_WrBack, 32'h44);
    check("wb link rd", {27'd0, WB_RegDest}, 32'd31);

    // read and write together returns the old word
    issue(1'b1, 5'd2, 1'b1, 1'b1, 2'b01, 32'h10, 32'h1234_5678);
    nop();
    check("rmw old", WB_WrBack, 32'hDEAD_BEEF);
    load(5'd2, 32'h10);
    nop();
    check("rmw new", WB_WrBack, 32'h1234_5678);

    // peripherals
    store(32'h4000_000C, 32'h0000_01A5);
    nop();
    check("led", {24'd0, led}, 32'hA5);
    store(32'h4000_0014, 32'h0000_FABC);
    nop();
    check("digi", {20'd0, digi}, 32'hABC);
    load(5'd1, 32'h4000_000C);
    nop();
    check("led rd", WB_WrBack, 32'hA5);
    switch = 8'h3C;
    load(5'd1, 32'h4000_0010);
    nop();
    check("sw rd", WB_WrBack, 32'h3C);
    store(32'h4000_0010, 32'hFFFF_FFFF);
    load(5'd1, 32'h4000_0013);
    nop();
    check("sw ro", WB_WrBack, 32'h3C);
    load(5'd1, 32'h5000_0000);
    nop();
    check("unmap", WB_WrBack, 32'd0);
    load(5'd1, 32'h0000_0400);
    nop();
    check("ram end", WB_WrBack, 32'd0);

`ifdef PERIPH_TIMER_EN
    store(32'h4000_0000, 32'hFFFF_FFFD);
    store(32'h4000_0004, 32'hFFFF_FFFE);
    store(32'h4000_0008, 32'd3);
    nop();
    check("tmr irq0", {31'd0, irq}, 32'd0);
    nop();
    check("tmr irq1", {31'd0, irq}, 32'd0);
    nop();
    check("tmr irq wrap", {31'd0, irq}, 32'd1);
    load(5'd1, 32'h4000_0004);
    nop();
    check("tmr tl", WB_WrBack, 32'hFFFF_FFFE);
    load(5'd1, 32'h4000_0008);
    nop();
    check("tmr tcon", WB_WrBack, 32'd7);
    store(32'h4000_0008, 32'd3);
    nop();
    check("tmr clr", {31'd0, irq}, 32'd0);
`else
    store(32'h4000_0008, 32'd3);
    nop();
    load(5'd1, 32'h4000_0008);
    nop();
    check("notmr tcon", WB_WrBack, 32'd0);
    repeat (3) nop();
    check("notmr irq", {31'd0, irq}, 32'd0);
`endif

    // store held in EX/MEM across reset is dropped
    store(32'h20, 32'h1111_1111);
    store(32'h20, 32'h2222_2222);
    reset       = 1'b1;
    EX_MemWrite = 1'b0;
    EX_ALUOut   = '0;
    EX_WrData   = '0;
    @(posedge clk);
    #1;
    check_all_zero("rst2");
    reset = 1'b0;
    load(5'd6, 32'h20);
    nop();
    check("rst ram", WB_WrBack, 32'h1111_1111);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory stage of the five-stage pipeline: consumes the EX stage's ALU result and store data, holds them in the EX/MEM pipeline register, performs data-RAM and memory-mapped peripheral access, and drives the MEM/WB register. It also returns the EX/MEM result to EX as the MEM-level forwarding source. The MEM stage never stalls.

## Interface
- Parameters:
  - RAM_WORDS, 256, data RAM depth in 32-bit words (power of two).
- Ports:
  - clk  in  1  system clock, rising edge.
  - reset  in  1  synchronous, active-high.
  - EX_RegWrite  in  1  register write enable from EX.
  - EX_RegDest  in  5  destination register from EX.
  - EX_MemRead  in  1  load.
  - EX_MemWrite  in  1  store.
  - EX_MemtoReg  in  2  writeback select; 2'b01 = memory data, any other value = ALU/PC value.
  - EX_ALUOut  in  32  EX result (already PC/PC+4 for link instructions); memory address for loads and stores.
  - EX_WrData  in  32  forwarded store data.
  - switch  in  8  board switches, read-only peripheral.
  - MEMForwardSrc  out  32  EX/MEM ALUOut, fed back to EX.
  - MEM_RegWrite  out  1  EX/MEM RegWrite, for the forwarding unit.
  - MEM_RegDest  out  5  EX/MEM RegDest, for the forwarding unit.
  - WB_RegWrite  out  1  MEM/WB RegWrite.
  - WB_RegDest  out  5  MEM/WB RegDest.
  - WB_WrBack  out  32  MEM/WB writeback data; also WBForwardSrc.
  - led  out  8  LED register.
  - digi  out  12  seven-segment register.
  - irq  out  1  timer interrupt request.

## Operation
- EX/MEM register captures all EX_* inputs every cycle.
- Address decode on EX/MEM ALUOut; bits [1:0] ignored (word access only).
  - 0x0000_0000–(RAM_WORDS*4-1): RAM, index = addr[log2(RAM_WORDS)+1:2].
  - 0x4000_0000 TH; 0x4000_0004 TL; 0x4000_0008 TCON[2:0] (bit0 enable, bit1 irq enable, bit2 irq status); 0x4000_000C led[7:0]; 0x4000_0010 switch (read-only); 0x4000_0014 digi[11:0].
  - Unmapped reads return 0; unmapped writes and writes to switch are ignored. Narrow registers read zero-extended.
- Reads are combinational within MEM. Writes commit at the end of the MEM cycle.
- MemRead and MemWrite together: the write is performed, and the read returns the old value.
- Writeback: WB_WrBack is the read data when MemtoReg == 2'b01; otherwise it is ALUOut.
- Timer: when TCON[0] = 1, TL increments each cycle. When TL == 32'hFFFF_FFFF, TL loads TH and TCON[2] is set if TCON[1] = 1.
  - irq = TCON[1] & TCON[2].
  - A CPU write to TL or TCON in the same cycle as a timer update wins.
  - Software clears the status by writing TCON.

## Timing
- Latency: EX_* at edge N appears on MEM_* and MEMForwardSrc after edge N; the WB_* result appears after edge N+1.
- Throughput: one access per cycle.
- Reset, sampled on the clock edge:
  - Cleared to 0: the EX/MEM and MEM/WB registers, TH, TL, TCON, led and digi. All outputs are therefore 0 and irq is 0.
  - RAM contents are preserved.
  - A store sitting in EX/MEM during a reset cycle is suppressed.

## Configuration
- PERIPH_TIMER_EN defined: TH, TL and TCON are implemented as described above.
- PERIPH_TIMER_EN undefined: those three addresses read 0, writes to them are ignored, and irq is tied to 0.
- LED, digi, switch and RAM behaviour is unaffected by the macro.

## Structure
- Package mem_pkg holds:
  - the address constants (RAM base, TH, TL, TCON, LED, SWITCH, DIGI);
  - the MemtoReg encoding constants;
  - the TCON bit indices.
- Sub-module data_ram: RAM_WORDS × 32, asynchronous read, synchronous write, no reset.

## Test plan
- Store 0xDEADBEEF to 0x10, then load from 0x10 with MemtoReg = 01: WB_WrBack = 0xDEADBEEF two cycles after the load is issued; WB_RegDest is as issued.
- Back-to-back ALU ops with ALUOut 5 then 7: MEMForwardSrc = 5, then 7, on consecutive cycles.
- Write TH = 0xFFFF_FFFD, TL = 0xFFFF_FFFE, TCON = 3: TL wraps to 0xFFFF_FFFD and irq rises the cycle after the wrap. Writing TCON = 3 clears irq.
- Store 0x1A5 to 0x4000_000C: led = 0xA5. Load 0x4000_0010 with switch = 0x3C: WB_WrBack = 0x3C. Load 0x5000_0000: WB_WrBack = 0.
- Assert reset while a store to 0x20 is in EX/MEM: RAM[8] is unchanged, and all outputs are 0 after the edge.
- Build without PERIPH_TIMER_EN, write TCON = 3, then read it back: the read returns 0 and irq stays 0.
